// File: rtl/reg_file_sb.sv
// Parametrised register file with a per-register pending-write scoreboard.
// Define RF_BYPASS_EN to forward same-cycle writeback data to the read ports.
module reg_file_sb #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int NRD = 2
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*DW-1:0]   rd,
  output logic [NRD-1:0]      rbusy,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [DW-1:0]       wd,
  input  logic                iss,
  input  logic [AW-1:0]       isd,
  input  logic                flush,
  output logic [AW:0]         nbusy
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    regs_r [DEPTH];
  logic [DEPTH-1:0] busy_r;
  logic [DEPTH-1:0] busy_s;
  logic [AW:0]      nbusy_r;
  logic             wr_en_s;
  logic             iss_en_s;

  // Number of set bits in a busy vector; DEPTH always fits in AW+1 bits.
  function automatic logic [AW:0] popcount(input logic [DEPTH-1:0] v);
    logic [AW:0] cnt;
    cnt = {(AW+1){1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + {{AW{1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  // Qualified write and issue strobes; register 0 never participates.
  always_comb begin
    wr_en_s  = we  && (wa  != {AW{1'b0}});
    iss_en_s = iss && (isd != {AW{1'b0}});
  end

  // Data array: writeback updates one entry, reset clears all of them.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= {DW{1'b0}};
      end
    end else if (wr_en_s) begin
      regs_r[wa] <= wd;
    end
  end

  // Next busy vector: writeback clears, a later issue to the same register
  // re-sets it since the newer producer is still in flight; flush wins over both.
  always_comb begin
    busy_s = busy_r;
    if (flush) begin
      busy_s = {DEPTH{1'b0}};
    end else begin
      if (wr_en_s) begin
        busy_s[wa] = 1'b0;
      end else begin
        busy_s = busy_s;
      end
      if (iss_en_s) begin
        busy_s[isd] = 1'b1;
      end else begin
        busy_s = busy_s;
      end
    end
    busy_s[0] = 1'b0;
  end

  // Scoreboard state and its registered population count move together.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      busy_r  <= {DEPTH{1'b0}};
      nbusy_r <= {(AW+1){1'b0}};
    end else begin
      busy_r  <= busy_s;
      nbusy_r <= popcount(busy_s);
    end
  end

  assign nbusy = nbusy_r;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr_s;
    logic [DW-1:0] data_s;
    logic          busy_bit_s;

    // Combinational read port k.
    always_comb begin
      addr_s     = ra[k*AW +: AW];
      data_s     = regs_r[addr_s];
      busy_bit_s = busy_r[addr_s];
`ifdef RF_BYPASS_EN
      if (wr_en_s && (addr_s == wa)) begin
        data_s     = wd;
        busy_bit_s = iss && (isd == wa);
      end else begin
        data_s     = data_s;
      end
`endif
      if (addr_s == {AW{1'b0}}) begin
        data_s     = {DW{1'b0}};
        busy_bit_s = 1'b0;
      end else begin
        data_s     = data_s;
      end
    end

    assign rd[k*DW +: DW] = data_s;
    assign rbusy[k]       = busy_bit_s;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed table-driven bench for reg_file_sb (DW=32, AW=5, NRD=2).
module tb_reg_file_sb;

  logic        CLK;
  logic        RESET;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  rbusy;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        iss;
  logic [4:0]  isd;
  logic        flush;
  logic [5:0]  nbusy;

  int checks = 0;
  int errors = 0;

  reg_file_sb #(.DW(32), .AW(5), .NRD(2)) dut (
    .CLK(CLK), .RESET(RESET), .ra(ra), .rd(rd), .rbusy(rbusy),
    .we(we), .wa(wa), .wd(wd), .iss(iss), .isd(isd), .flush(flush),
    .nbusy(nbusy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iss;
    logic [4:0]  isd;
    logic        flush;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [1:0]  e_rbusy;
    logic [5:0]  e_nbusy;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    we = 1'b0; wa = 5'd0; wd = 32'd0; iss = 1'b0; isd = 5'd0; flush = 1'b0;
  endtask

  // Drive controls for one edge, then release them and look at the outputs.
  task automatic step(input logic w, input logic [4:0] a, input logic [31:0] d,
                      input logic i, input logic [4:0] id, input logic f);
    we = w; wa = a; wd = d; iss = i; isd = id; flush = f;
    @(posedge CLK);
    #1;
    idle();
    #1;
  endtask

  initial begin
    idle();
    RESET = 1'b1;
    ra = {5'd31, 5'd5};
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    #1;

    //        we   wa     wd            iss  isd    fl   ra0    ra1    rd0           rd1           rbusy  nbusy
    vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd5,  5'd31, 32'h0,        32'h0,        2'b00, 6'd0};
    vecs[1]  = '{1'b1, 5'd7,  32'hDEADBEEF, 1'b0, 5'd0,  1'b0, 5'd0,  5'd7,  32'h0,        32'hDEADBEEF, 2'b00, 6'd0};
    vecs[2]  = '{1'b1, 5'd0,  32'h1234,     1'b0, 5'd0,  1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 6'd0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b0, 5'd9,  5'd7,  32'h0,        32'hDEADBEEF, 2'b01, 6'd1};
    vecs[4]  = '{1'b1, 5'd9,  32'h55,       1'b0, 5'd0,  1'b0, 5'd9,  5'd9,  32'h55,       32'h55,       2'b00, 6'd0};
    vecs[5]  = '{1'b1, 5'd3,  32'hA5,       1'b1, 5'd3,  1'b0, 5'd3,  5'd9,  32'hA5,       32'h55,       2'b01, 6'd1};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b1, 5'd3,  5'd3,  32'hA5,       32'hA5,       2'b00, 6'd0};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 6'd0};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  1'b0, 5'd5,  5'd5,  32'h0,        32'h0,        2'b11, 6'd1};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd6,  1'b0, 5'd6,  5'd5,  32'h0,        32'h0,        2'b11, 6'd2};
    vecs[10] = '{1'b1, 5'd6,  32'h66,       1'b1, 5'd8,  1'b1, 5'd8,  5'd6,  32'h0,        32'h66,       2'b00, 6'd0};
    vecs[11] = '{1'b1, 5'd10, 32'hAA,       1'b0, 5'd0,  1'b0, 5'd10, 5'd31, 32'hAA,       32'h0,        2'b00, 6'd0};
    vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 1'b0, 5'd31, 5'd31, 32'h0,        32'h0,        2'b11, 6'd1};
    vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd1,  1'b0, 5'd1,  5'd31, 32'h0,        32'h0,        2'b11, 6'd2};
    vecs[14] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd2,  1'b0, 5'd31, 5'd2,  32'hFFFFFFFF, 32'h0,        2'b10, 6'd2};

    // Reset state before any traffic.
    check("reset_rd0", rd[31:0], 32'h0);
    check("reset_rd1", rd[63:32], 32'h0);
    check("reset_rbusy", {30'd0, rbusy}, 32'h0);
    check("reset_nbusy", {26'd0, nbusy}, 32'h0);

    for (int i = 0; i < 15; i++) begin
      ra = {vecs[i].ra1, vecs[i].ra0};
      step(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].iss, vecs[i].isd, vecs[i].flush);
      check($sformatf("v%0d_rd0", i), rd[31:0], vecs[i].e_rd0);
      check($sformatf("v%0d_rd1", i), rd[63:32], vecs[i].e_rd1);
      check($sformatf("v%0d_rbusy", i), {30'd0, rbusy}, {30'd0, vecs[i].e_rbusy});
      check($sformatf("v%0d_nbusy", i), {26'd0, nbusy}, {26'd0, vecs[i].e_nbusy});
    end

    // Same-cycle writeback visibility on a read port.
    step(1'b1, 5'd4, 32'h11, 1'b0, 5'd0, 1'b1);
    ra = {5'd5, 5'd4};
    we = 1'b1; wa = 5'd4; wd = 32'h22; iss = 1'b1; isd = 5'd5;
    #1;
`ifdef RF_BYPASS_EN
    check("byp_same_rd", rd[31:0], 32'h22);
`else
    check("byp_same_rd", rd[31:0], 32'h11);
    check("iss_no_comb_rbusy", {30'd0, rbusy}, 32'h0);
`endif
    check("byp_same_rbusy0", {31'd0, rbusy[0]}, 32'h0);
    @(posedge CLK);
    #1;
    idle();
    #1;
    check("byp_next_rd", rd[31:0], 32'h22);
    check("byp_next_rbusy1", {31'd0, rbusy[1]}, 32'h1);

    // Reset in the middle of traffic discards that cycle's write and issue.
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
    step(1'b1, 5'd2, 32'h99, 1'b0, 5'd0, 1'b0);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0);
    ra = {5'd3, 5'd2};
    #1;
    check("pre_rst_rd2", rd[31:0], 32'h99);
    check("pre_rst_rbusy", {30'd0, rbusy}, 32'h3);
    check("pre_rst_nbusy", {26'd0, nbusy}, 32'h2);
    RESET = 1'b1;
    we = 1'b1; wa = 5'd2; wd = 32'h77; iss = 1'b1; isd = 5'd4;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    idle();
    #1;
    check("rst_rd2", rd[31:0], 32'h0);
    check("rst_rbusy", {30'd0, rbusy}, 32'h0);
    check("rst_nbusy", {26'd0, nbusy}, 32'h0);
    ra = {5'd4, 5'd7};
    #1;
    check("rst_rd7", rd[31:0], 32'h0);
    check("rst_rbusy4", {31'd0, rbusy[1]}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
